// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode: DEPTH bundles of {instrs, pc},
// show-ahead head, flush on misprediction, no enqueue-to-dequeue bypass.
package op_pkg;
  localparam int unsigned INSTRUCTION_WIDTH  = 32;
  localparam int unsigned SUPER_SCALAR_WIDTH = 4;
endpackage

module fetch_queue #(
  parameter int unsigned INSTRUCTION_WIDTH  = op_pkg::INSTRUCTION_WIDTH,
  parameter int unsigned SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter int unsigned DEPTH              = 4
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          flush_in,
  input  logic                                          enq_valid_in,
  input  logic [INSTRUCTION_WIDTH*SUPER_SCALAR_WIDTH-1:0] enq_instrs_in,
  input  logic [63:0]                                   enq_pc_in,
  output logic                                          enq_ready_out,
  output logic                                          deq_valid_out,
  output logic [INSTRUCTION_WIDTH*SUPER_SCALAR_WIDTH-1:0] deq_instrs_out,
  output logic [63:0]                                   deq_pc_out,
  input  logic                                          deq_ready_in,
  output logic [$clog2(DEPTH):0]                        occupancy_out
);

  localparam int unsigned BW = INSTRUCTION_WIDTH * SUPER_SCALAR_WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [BW-1:0] instrs_q [DEPTH];
  logic [63:0]   pc_q     [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] count_q, count_d;

  logic full, empty, enq_fire, deq_fire;

  // Wrap bit distinguishes full from empty when the indices coincide.
  always_comb begin
    full     = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    empty    = (head_q == tail_q);
    enq_fire = enq_valid_in & enq_ready_out;
    deq_fire = deq_valid_out & deq_ready_in;
  end

  assign enq_ready_out  = ~full & ~flush_in;
  assign deq_valid_out  = ~empty & ~flush_in;
  assign deq_instrs_out = empty ? '0 : instrs_q[head_q[AW-1:0]];
  assign deq_pc_out     = empty ? '0 : pc_q[head_q[AW-1:0]];
  assign occupancy_out  = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq_fire) head_d = head_q + PW'(1);
      if (enq_fire) tail_d = tail_q + PW'(1);
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instrs_q[i] <= '0;
        pc_q[i]     <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq_fire) begin
        instrs_q[tail_q[AW-1:0]] <= enq_instrs_in;
        pc_q[tail_q[AW-1:0]]     <= enq_pc_in;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus a
// long random run compared each cycle against a queue-based reference.
module tb_fetch_queue;

  localparam int unsigned IW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned BW = IW * SW;
  localparam int unsigned D  = 4;

  typedef struct {
    logic [BW-1:0] ins;
    logic [63:0]   pc;
  } bundle_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          enq_v = 1'b0;
  logic [BW-1:0] enq_ins = '0;
  logic [63:0]   enq_pc = '0;
  logic          enq_rdy;
  logic          deq_v;
  logic [BW-1:0] deq_ins;
  logic [63:0]   deq_pc;
  logic          deq_rdy = 1'b0;
  logic [2:0]    occ;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bundle_t mq[$];

  fetch_queue #(.INSTRUCTION_WIDTH(IW), .SUPER_SCALAR_WIDTH(SW), .DEPTH(D)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .enq_valid_in(enq_v), .enq_instrs_in(enq_ins), .enq_pc_in(enq_pc),
    .enq_ready_out(enq_rdy), .deq_valid_out(deq_v), .deq_instrs_out(deq_ins),
    .deq_pc_out(deq_pc), .deq_ready_in(deq_rdy), .occupancy_out(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk(input logic [63:0] pc);
    return {pc[31:0] + 32'd3, pc[31:0] + 32'd2, pc[31:0] + 32'd1, pc[31:0]};
  endfunction

  // Reference: a bounded FIFO of bundles; flush/reset empty it.
  always @(posedge clk) begin
    bit ef, df;
    ef = enq_v && (mq.size() < D) && !flush;
    df = deq_rdy && (mq.size() > 0) && !flush;
    if (rst || flush) mq.delete();
    else begin
      if (df) void'(mq.pop_front());
      if (ef) mq.push_back('{ins: enq_ins, pc: enq_pc});
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      bit ne;
      ne = (mq.size() > 0);
      chk("occupancy", BW'(occ), BW'(mq.size()));
      chk("enq_ready", BW'(enq_rdy), BW'((mq.size() < D) && !flush));
      chk("deq_valid", BW'(deq_v), BW'(ne && !flush));
      chk("deq_instrs", deq_ins, ne ? mq[0].ins : '0);
      chk("deq_pc", BW'(deq_pc), ne ? BW'(mq[0].pc) : '0);
    end
  end

  task automatic step(input bit r, input bit f, input bit ev, input logic [63:0] pc,
                      input bit dr);
    @(posedge clk);
    #1;
    rst = r; flush = f; enq_v = ev; enq_pc = pc; enq_ins = mk(pc); deq_rdy = dr;
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;

    // Reset state
    step(1, 0, 0, 64'h0, 0);
    #2;
    chk("rst_occ", BW'(occ), '0);
    chk("rst_enq_ready", BW'(enq_rdy), BW'(1));
    chk("rst_deq_valid", BW'(deq_v), '0);
    chk("rst_deq_pc", BW'(deq_pc), '0);

    // Single enqueue, one-cycle latency
    step(0, 0, 1, 64'h1000, 0);
    enq_ins = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    step(0, 0, 0, 64'h0, 0);
    #2;
    chk("lat_valid", BW'(deq_v), BW'(1));
    chk("lat_pc", BW'(deq_pc), BW'(64'h1000));
    chk("lat_occ", BW'(occ), BW'(1));
    chk("lat_instrs", deq_ins, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

    // Fill to full, held 5th bundle, no pass-through
    step(1, 0, 0, 64'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 64'h1000 + 64'(16 * i), 0);
    step(0, 0, 1, 64'h1040, 0);
    #2;
    chk("full_occ", BW'(occ), BW'(4));
    chk("full_ready", BW'(enq_rdy), '0);
    step(0, 0, 1, 64'h1040, 1);
    #2;
    chk("full_deq_ready", BW'(enq_rdy), '0);
    chk("full_deq_pc", BW'(deq_pc), BW'(64'h1000));
    step(0, 0, 1, 64'h1040, 0);
    #2;
    chk("after_deq_ready", BW'(enq_rdy), BW'(1));
    chk("after_deq_occ", BW'(occ), BW'(3));
    step(0, 0, 0, 64'h0, 0);
    #2;
    chk("refill_occ", BW'(occ), BW'(4));
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 64'h0, 1);
      #2;
      chk("drain_pc", BW'(deq_pc), BW'(64'h1000 + 64'(16 * i)));
    end
    step(0, 0, 0, 64'h0, 0);
    #2;
    chk("drained_occ", BW'(occ), '0);

    // Simultaneous enq/deq at occupancy 2 across pointer wrap
    step(1, 0, 0, 64'h0, 0);
    step(0, 0, 1, 64'h1000, 0);
    step(0, 0, 1, 64'h1010, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 64'h1020 + 64'(16 * i), 1);
      #2;
      chk("both_pc", BW'(deq_pc), BW'(64'h1000 + 64'(16 * i)));
      chk("both_occ", BW'(occ), BW'(2));
    end

    // Flush at occupancy 3 with both handshakes requested
    step(1, 0, 0, 64'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 64'h5000 + 64'(16 * i), 0);
    step(0, 1, 1, 64'h6000, 1);
    #2;
    chk("flush_valid", BW'(deq_v), '0);
    chk("flush_ready", BW'(enq_rdy), '0);
    chk("flush_occ_pre", BW'(occ), BW'(3));
    step(0, 0, 0, 64'h0, 0);
    #2;
    chk("postflush_occ", BW'(occ), '0);
    chk("postflush_instrs", deq_ins, '0);
    chk("postflush_valid", BW'(deq_v), '0);
    step(0, 0, 1, 64'h7000, 0);
    step(0, 0, 0, 64'h0, 0);
    #2;
    chk("postflush_pc", BW'(deq_pc), BW'(64'h7000));
    chk("postflush_occ1", BW'(occ), BW'(1));

    // Reset mid-operation at occupancy 2
    step(0, 0, 1, 64'h8000, 0);
    step(1, 0, 0, 64'h0, 0);
    step(0, 0, 1, 64'h2000, 0);
    #2;
    chk("midrst_occ", BW'(occ), '0);
    chk("midrst_valid", BW'(deq_v), '0);
    step(0, 0, 0, 64'h0, 0);
    #2;
    chk("midrst_pc", BW'(deq_pc), BW'(64'h2000));

    // Random traffic; upstream holds a refused bundle
    begin
      logic [63:0] pc;
      bit ev;
      pc = 64'h10000;
      ev = 1'b0;
      for (int c = 0; c < 10000; c++) begin
        bit accepted;
        accepted = enq_v && enq_rdy;
        if (accepted || !ev) begin
          if (accepted) pc = pc + 64'h10;
          ev = ($urandom_range(0, 9) < 6);
        end
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0), ev, pc,
             ($urandom_range(0, 1) == 1));
      end
    end
    step(0, 0, 0, 64'h0, 0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
